// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multi-cycle ARM control unit.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  // ALU op codes; shifts use the pass-B op with a shift select
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_ORR = 3;
  localparam int ALU_SHF = 4;

  localparam int SH_NONE = 0;
  localparam int SH_LSR  = 1;
  localparam int SH_LSL  = 2;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'ha, C_LT = 4'hb;
  localparam logic [3:0] C_GT = 4'hc, C_LE = 4'hd, C_AL = 4'he, C_NV = 4'hf;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] IMM_8 = 2'b00, IMM_12 = 2'b01, IMM_24 = 2'b10;

  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      C_EQ: return z;
      C_NE: return ~z;
      C_CS: return c;
      C_CC: return ~c;
      C_MI: return n;
      C_PL: return ~n;
      C_VS: return v;
      C_VC: return ~v;
      C_HI: return c & ~z;
      C_LS: return ~c | z;
      C_GE: return n == v;
      C_LT: return n != v;
      C_GT: return ~z & (n == v);
      C_LE: return z | (n != v);
      C_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_alu_dec.sv
// Data-processing decoder: Funct[4:0] -> ALU op, shift select, NoWrite, flag-write enables.
module arm_mc_alu_dec
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int SHIFT_W   = 2
) (
  input  logic [4:0]           funct,
  output logic [ALUCTRL_W-1:0] alu_ctrl,
  output logic [SHIFT_W-1:0]   shift,
  output logic                 nowrite,
  output logic [1:0]           flagw     // [1]=NZ, [0]=CV
);
  logic arith;

  always_comb begin
    alu_ctrl = '0;
    shift    = '0;
    nowrite  = 1'b0;
    arith    = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_ctrl = ALUCTRL_W'(ALU_ADD); arith = 1'b1; end
      4'b0010: begin alu_ctrl = ALUCTRL_W'(ALU_SUB); arith = 1'b1; end
      4'b0000: alu_ctrl = ALUCTRL_W'(ALU_AND);
      4'b1100: alu_ctrl = ALUCTRL_W'(ALU_ORR);
      4'b1101: begin alu_ctrl = ALUCTRL_W'(ALU_SHF); shift = SHIFT_W'(SH_LSR); end
      4'b1110: begin alu_ctrl = ALUCTRL_W'(ALU_SHF); shift = SHIFT_W'(SH_LSL); end
      4'b1010: begin alu_ctrl = ALUCTRL_W'(ALU_SUB); arith = 1'b1; nowrite = 1'b1; end
      default: ;
    endcase
    flagw = {funct[0], funct[0] & arith};
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multi-cycle ARM control unit: main FSM, condition check and NZCV register.
// Define ARM_MC_BL_EN to have BL write the return address to R14 in BRANCH.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int         ALUCTRL_W = 3,
  parameter int         SHIFT_W   = 2,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegW,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [SHIFT_W-1:0]   shift,
  output logic [3:0]           Flags,
  output logic                 Undef,
  output logic [3:0]           StateDbg
);
  state_e                 state, nstate;
  logic                   cond_ex_q;
  logic [3:0]             flags_q;
  logic [ALUCTRL_W-1:0]   dec_alu;
  logic [SHIFT_W-1:0]     dec_sh;
  logic                   nowrite, is_bl, exec_st, pc_dst;
  logic [1:0]             flagw;

  arm_mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W), .SHIFT_W(SHIFT_W)) u_alu_dec (
    .funct(Funct[4:0]), .alu_ctrl(dec_alu), .shift(dec_sh), .nowrite(nowrite), .flagw(flagw)
  );

`ifdef ARM_MC_BL_EN
  assign is_bl = Funct[4];
`else
  assign is_bl = 1'b0;
`endif

  assign exec_st  = (state == S_EXECR) || (state == S_EXECI);
  assign pc_dst   = (Rd == 4'hf);
  assign Flags    = flags_q;
  assign StateDbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      flags_q   <= FLAGS_RST;
      cond_ex_q <= 1'b0;
    end else begin
      state <= nstate;
      if (state == S_DECODE) cond_ex_q <= cond_ex(Cond, flags_q);
      // a failed condition suppresses the flag update along with all writes
      if (exec_st && cond_ex_q) begin
        if (flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nstate     = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    RegW       = 1'b0;
    ALUControl = '0;
    shift      = '0;
    Undef      = 1'b0;
    // reset aborts the sequence with every output held at its default
    if (!reset) begin
      case (state)
        S_FETCH: begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          ResultSrc  = RES_ALURES;
          ALUControl = ALUCTRL_W'(ALU_ADD);
          nstate     = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          ImmSrc    = (Op == 2'b11) ? IMM_8 : Op;
          RegSrc    = {Op == 2'b01, Op == 2'b10};
          case (Op)
            2'b00:   nstate = Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   nstate = S_MEMADR;
            2'b10:   nstate = S_BRANCH;
            default: begin nstate = S_FETCH; Undef = 1'b1; end
          endcase
        end
        S_MEMADR: begin
          ALUSrcB    = SRCB_IMM;
          ALUControl = ALUCTRL_W'(ALU_ADD);
          nstate     = Funct[0] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          AdrSrc = 1'b1;
          nstate = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegW      = cond_ex_q;
          PCWrite   = cond_ex_q & pc_dst;
        end
        S_MEMWR: begin
          AdrSrc = 1'b1;
          MemW   = cond_ex_q;
        end
        S_EXECR, S_EXECI: begin
          ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
          ALUControl = dec_alu;
          shift      = dec_sh;
          nstate     = S_ALUWB;
        end
        S_ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegW      = cond_ex_q & ~nowrite;
          PCWrite   = cond_ex_q & ~nowrite & pc_dst;
        end
        S_BRANCH: begin
          ImmSrc    = IMM_24;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALURES;
          PCWrite   = cond_ex_q;
          if (is_bl) begin
            RegW      = cond_ex_q;
            RegSrc    = 2'b01;
            ResultSrc = RES_ALUOUT;
          end
        end
        default: nstate = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench: instruction-level expected-output queue plus literal latency/flag checks.
module tb_arm_mc_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemW, IRWrite, ALUSrcA, RegW, Undef;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, shift;
  logic [2:0] ALUControl;
  logic [3:0] Flags, StateDbg;

  always #5 clk = ~clk;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemW(MemW), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegW(RegW),
    .ALUControl(ALUControl), .shift(shift), .Flags(Flags), .Undef(Undef), .StateDbg(StateDbg)
  );

  typedef struct packed {
    logic       pcw, adr, memw, irw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb, imm, regsrc;
    logic       regw;
    logic [2:0] aluc;
    logic [1:0] sh;
    logic       undef;
    logic [3:0] st;
    logic [3:0] flags;
  } exp_t;

  exp_t       q[$];
  exp_t       cmp_e, cmp_a, rst_e;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mflags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cmp_e = q.pop_front();
      cmp_a = {PCWrite, AdrSrc, MemW, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
               RegW, ALUControl, shift, Undef, StateDbg, Flags};
      checks++;
      if (cmp_a !== cmp_e) begin
        errors++;
        $display("FAIL cycle_outputs: got %h expected %h at %0t", cmp_a, cmp_e, $time);
      end
    end
  end

  function automatic logic condex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hf) return 1'b0;
    if (c == 4'he) return 1'b1;
    return c[0] ? !r : r;
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.flags = mflags;
    return e;
  endfunction

  // Expected per-cycle outputs of one instruction, straight from the state-sequence rules.
  task automatic model(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] alf);
    exp_t e;
    logic ce, nw, cv;
    logic [2:0] ac;
    logic [1:0] sh;
    e = blank(4'd0); e.irw = 1; e.pcw = 1; e.srca = 1; e.srcb = 2; e.res = 2; q.push_back(e);
    ce = condex(c, mflags);
    e = blank(4'd1); e.srca = 1; e.srcb = 2; e.res = 2;
    e.imm = (op == 2'd3) ? 2'd0 : op; e.regsrc = {op == 2'd1, op == 2'd2}; e.undef = (op == 2'd3);
    q.push_back(e);
    case (op)
      2'd1: begin
        e = blank(4'd2); e.srcb = 1; q.push_back(e);
        if (fn[0]) begin
          e = blank(4'd3); e.adr = 1; q.push_back(e);
          e = blank(4'd4); e.res = 1; e.regw = ce; e.pcw = ce && rd == 4'hf; q.push_back(e);
        end else begin
          e = blank(4'd5); e.adr = 1; e.memw = ce; q.push_back(e);
        end
      end
      2'd0: begin
        {ac, sh, nw, cv} = '0;
        case (fn[4:1])
          4'b0100: cv = 1;
          4'b0010: begin ac = 3'd1; cv = 1; end
          4'b0000: ac = 3'd2;
          4'b1100: ac = 3'd3;
          4'b1101: begin ac = 3'd4; sh = 2'd1; end
          4'b1110: begin ac = 3'd4; sh = 2'd2; end
          4'b1010: begin ac = 3'd1; cv = 1; nw = 1; end
          default: ;
        endcase
        e = blank(fn[5] ? 4'd7 : 4'd6); e.srcb = fn[5] ? 2'd1 : 2'd0; e.aluc = ac; e.sh = sh;
        q.push_back(e);
        if (ce && fn[0]) begin
          mflags[3:2] = alf[3:2];
          if (cv) mflags[1:0] = alf[1:0];
        end
        e = blank(4'd8); e.regw = ce && !nw; e.pcw = ce && !nw && rd == 4'hf; q.push_back(e);
      end
      2'd2: begin
        e = blank(4'd9); e.imm = 2; e.srcb = 1; e.res = 2; e.pcw = ce; q.push_back(e);
      end
      default: ;
    endcase
  endtask

  task automatic run(input string name, input logic [3:0] c, input logic [1:0] op,
                     input logic [5:0] fn, input logic [3:0] rd, input logic [3:0] alf,
                     input int lat);
    int cnt;
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = alf;
    model(c, op, fn, rd, alf);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (StateDbg != 4'd0 && cnt < 8);
    check({name, "_latency"}, cnt, lat);
    check({name, "_leftover"}, q.size(), 0);
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; Cond = 0; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
    mflags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", StateDbg, 0);
    check("rst_flags", Flags, 4'b0000);
    check("rst_irwrite", IRWrite, 0);
    check("rst_pcwrite", PCWrite, 0);
    reset = 0;

    run("adds",       4'he, 2'd0, 6'b001001, 4'd1,  4'b0100, 4);
    check("adds_flags", Flags, 4'b0100);
    run("ldr",        4'he, 2'd1, 6'b011001, 4'd2,  4'b0000, 5);
    run("orrs",       4'he, 2'd0, 6'b011001, 4'd3,  4'b1011, 4);
    check("orrs_flags", Flags, 4'b1000);
    run("streq_fail", 4'h0, 2'd1, 6'b011000, 4'd4,  4'b0000, 4);
    run("cmp",        4'he, 2'd0, 6'b010101, 4'd0,  4'b0100, 4);
    check("cmp_flags", Flags, 4'b0100);
    run("beq",        4'h0, 2'd2, 6'b100000, 4'd0,  4'b0000, 3);
    run("blne_as_b",  4'h1, 2'd2, 6'b110000, 4'd0,  4'b0000, 3);
    run("undef",      4'he, 2'd3, 6'b000000, 4'd0,  4'b0000, 2);
    run("subs_imm",   4'he, 2'd0, 6'b100101, 4'd5,  4'b0011, 4);
    check("subs_flags", Flags, 4'b0011);
    run("lsls",       4'he, 2'd0, 6'b011101, 4'd6,  4'b1000, 4);
    check("lsls_flags", Flags, 4'b1011);
    run("lsr_nos",    4'he, 2'd0, 6'b011010, 4'd7,  4'b0000, 4);
    run("and_pc",     4'he, 2'd0, 6'b000000, 4'hf,  4'b0000, 4);
    run("adds_nv",    4'hf, 2'd0, 6'b001001, 4'd1,  4'b0101, 4);
    check("nv_flags", Flags, 4'b1011);
    run("ldr_pc",     4'he, 2'd1, 6'b011001, 4'hf,  4'b0000, 5);

    // reset arrives while an LDR sits in MEMRD
    Cond = 4'he; Op = 2'd1; Funct = 6'b011001; Rd = 4'd2; ALUFlags = 4'b0000;
    model(4'he, 2'd1, 6'b011001, 4'd2, 4'b0000);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_state", StateDbg, 3);
    q.delete();
    reset = 1;
    rst_e = blank(4'd3);
    q.push_back(rst_e);
    @(posedge clk); #1;
    reset = 0;
    mflags = 4'b0000;
    check("midrst_state", StateDbg, 0);
    check("midrst_flags", Flags, 4'b0000);
    check("midrst_leftover", q.size(), 0);
    q.delete();

    run("adds_after", 4'he, 2'd0, 6'b001001, 4'd1,  4'b1000, 4);
    check("after_flags", Flags, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
